// File: rtl/rv32i_ctrl_pkg.sv
// Shared control encodings for the RV32I multicycle core: opcodes, FSM states,
// instruction classes and the datapath mux select codes.
package rv32i_ctrl_pkg;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // FSM state encoding, also exported on state_o
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_t;

  // Instruction class produced by the main decoder
  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
    CLS_STORE, CLS_OPIMM, CLS_OP, CLS_FENCE, CLS_SYSTEM, CLS_ILLEGAL
  } instr_class_t;

  // Immediate extender select
  localparam logic [1:0] EXT_U  = 2'b00;
  localparam logic [1:0] EXT_J  = 2'b01;
  localparam logic [1:0] EXT_B  = 2'b10;
  localparam logic [1:0] EXT_IS = 2'b11;

  // ALU operand A / B selects
  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;
  localparam logic       SRCB_RS2  = 1'b0;
  localparam logic       SRCB_IMM  = 1'b1;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_OP     = 2'b10;
  localparam logic [1:0] ALUOP_OPIMM  = 2'b11;

  // Next-PC source
  localparam logic [1:0] PCSRC_PLUS4 = 2'b00;
  localparam logic [1:0] PCSRC_IMM   = 2'b01;
  localparam logic [1:0] PCSRC_JALR  = 2'b10;

  // Register write-back source
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // True for classes that need a data-memory access
  function automatic logic is_mem_class(input instr_class_t c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

endpackage

// File: rtl/multicycle_controller_main_decoder.sv
// main_decoder: purely combinational opcode classification. Produces the
// instruction class, immediate format, ALU selects for EXECUTE and legality.
module main_decoder
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [3:0] class_o,
  output logic [1:0] extend_sel_o,
  output logic [1:0] alu_src_a_o,
  output logic       alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       legal_o
);

  instr_class_t cls;

  // Opcode lookup; defaults are the I/S-type "rs1 + imm" address form
  always_comb begin
    cls          = CLS_ILLEGAL;
    extend_sel_o = EXT_IS;
    alu_src_a_o  = SRCA_RS1;
    alu_src_b_o  = SRCB_IMM;
    alu_op_o     = ALUOP_ADD;
    legal_o      = 1'b1;
    case (opcode_i)
      OPC_LUI: begin
        cls          = CLS_LUI;
        extend_sel_o = EXT_U;
        alu_src_a_o  = SRCA_ZERO;
      end
      OPC_AUIPC: begin
        cls          = CLS_AUIPC;
        extend_sel_o = EXT_U;
        alu_src_a_o  = SRCA_PC;
      end
      OPC_JAL: begin
        cls          = CLS_JAL;
        extend_sel_o = EXT_J;
        alu_src_a_o  = SRCA_PC;
      end
      OPC_JALR:  cls = CLS_JALR;
      OPC_LOAD:  cls = CLS_LOAD;
      OPC_STORE: cls = CLS_STORE;
      OPC_OPIMM: begin
        cls      = CLS_OPIMM;
        alu_op_o = ALUOP_OPIMM;
      end
      OPC_OP: begin
        cls         = CLS_OP;
        alu_src_b_o = SRCB_RS2;
        alu_op_o    = ALUOP_OP;
      end
      OPC_BRANCH: begin
        cls          = CLS_BRANCH;
        extend_sel_o = EXT_B;
        alu_src_b_o  = SRCB_RS2;
        alu_op_o     = ALUOP_BRANCH;
      end
      OPC_FENCE:  cls = CLS_FENCE;
      OPC_SYSTEM: cls = CLS_SYSTEM;
      default:    legal_o = 1'b0;
    endcase
  end

  assign class_o = cls;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I
// multicycle core over one shared memory port. Outputs are decoded from the
// state register (plus opcode, branch result and memory ready) and forced to
// zero while rst_i is high, so an in-flight request drops immediately.
// Optional feature macro: ILLEGAL_TRAP_EN -- unknown opcodes park the FSM in
// TRAP with illegal_o set; when undefined they retire as a NOP.
module multicycle_controller
  import rv32i_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       mem_addr_sel_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] extend_sel_o,
  output logic [1:0] alu_src_a_o,
  output logic       alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       reg_write_o,
  output logic [1:0] wb_sel_o,
  output logic       instr_retired_o,
  output logic [2:0] state_o,
  output logic       illegal_o
);

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_t       state_reg;
  logic [3:0]   dec_class_raw;
  instr_class_t dec_class;
  logic [1:0]   dec_ext;
  logic [1:0]   dec_src_a;
  logic         dec_src_b;
  logic [1:0]   dec_alu_op;
  logic         dec_legal;
  logic         exec_retires;

  main_decoder u_main_decoder (
    .opcode_i     (opcode_i),
    .class_o      (dec_class_raw),
    .extend_sel_o (dec_ext),
    .alu_src_a_o  (dec_src_a),
    .alu_src_b_o  (dec_src_b),
    .alu_op_o     (dec_alu_op),
    .legal_o      (dec_legal)
  );

  assign dec_class = instr_class_t'(dec_class_raw);

  // Branches, FENCE/SYSTEM and (non-trapping) unknown opcodes finish in EXECUTE
  assign exec_retires = (dec_class == CLS_BRANCH) || (dec_class == CLS_FENCE) ||
                        (dec_class == CLS_SYSTEM) || !dec_legal;

  // State sequencing; TRAP is sticky until reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_FETCH;
    end else begin
      case (state_reg)
        ST_FETCH:   if (mem_ready_i) state_reg <= ST_DECODE;
        ST_DECODE:  state_reg <= (dec_legal || !TRAP_EN) ? ST_EXECUTE : ST_TRAP;
        ST_EXECUTE: begin
          if (is_mem_class(dec_class)) state_reg <= ST_MEM;
          else if (exec_retires)       state_reg <= ST_FETCH;
          else                         state_reg <= ST_WB;
        end
        ST_MEM: begin
          if (mem_ready_i) state_reg <= (dec_class == CLS_LOAD) ? ST_WB : ST_FETCH;
        end
        ST_WB:      state_reg <= ST_FETCH;
        ST_TRAP:    state_reg <= TRAP_EN ? ST_TRAP : ST_FETCH;
        default:    state_reg <= ST_FETCH;
      endcase
    end
  end

  // Output decode from current state; everything quiet while in reset
  always_comb begin
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_sel_o  = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_src_o        = PCSRC_PLUS4;
    extend_sel_o    = EXT_U;
    alu_src_a_o     = SRCA_RS1;
    alu_src_b_o     = SRCB_RS2;
    alu_op_o        = ALUOP_ADD;
    reg_write_o     = 1'b0;
    wb_sel_o        = WB_ALU;
    instr_retired_o = 1'b0;
    state_o         = 3'd0;
    illegal_o       = 1'b0;
    if (!rst_i) begin
      state_o = state_reg;
      case (state_reg)
        ST_FETCH: begin
          mem_req_o  = 1'b1;
          ir_write_o = mem_ready_i;
        end
        ST_DECODE: extend_sel_o = dec_ext;
        ST_EXECUTE: begin
          extend_sel_o = dec_ext;
          alu_src_a_o  = dec_src_a;
          alu_src_b_o  = dec_src_b;
          alu_op_o     = dec_alu_op;
          if (exec_retires) begin
            pc_write_o      = 1'b1;
            instr_retired_o = 1'b1;
            if (dec_class == CLS_BRANCH && branch_taken_i) pc_src_o = PCSRC_IMM;
          end
        end
        ST_MEM: begin
          extend_sel_o   = dec_ext;
          mem_req_o      = 1'b1;
          mem_addr_sel_o = 1'b1;
          mem_we_o       = (dec_class == CLS_STORE);
          if (mem_ready_i && dec_class == CLS_STORE) begin
            pc_write_o      = 1'b1;
            instr_retired_o = 1'b1;
          end
        end
        ST_WB: begin
          extend_sel_o    = dec_ext;
          reg_write_o     = 1'b1;
          pc_write_o      = 1'b1;
          instr_retired_o = 1'b1;
          case (dec_class)
            CLS_LOAD: wb_sel_o = WB_MEM;
            CLS_JAL: begin
              wb_sel_o = WB_PC4;
              pc_src_o = PCSRC_IMM;
            end
            CLS_JALR: begin
              wb_sel_o = WB_PC4;
              pc_src_o = PCSRC_JALR;
            end
            default: ;
          endcase
        end
        ST_TRAP: illegal_o = TRAP_EN;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is expanded
// into its expected per-cycle output record, pushed to a scoreboard queue when
// the cycle's stimulus is driven and compared at the following falling edge.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] extend_sel;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       instr_retired;
    logic [2:0] state;
    logic       illegal;
  } outs_t;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] opcode_i = 7'd0;
  logic       branch_taken_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o, pc_write_o;
  logic [1:0] pc_src_o, extend_sel_o, alu_src_a_o, alu_op_o, wb_sel_o;
  logic       alu_src_b_o, reg_write_o, instr_retired_o, illegal_o;
  logic [2:0] state_o;

  int    checks = 0;
  int    errors = 0;
  outs_t exp_q[$];
  outs_t care_q[$];
  string tag_q[$];

  always #5 clk_i = ~clk_i;

  multicycle_controller dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .opcode_i        (opcode_i),
    .branch_taken_i  (branch_taken_i),
    .mem_ready_i     (mem_ready_i),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_sel_o  (mem_addr_sel_o),
    .ir_write_o      (ir_write_o),
    .pc_write_o      (pc_write_o),
    .pc_src_o        (pc_src_o),
    .extend_sel_o    (extend_sel_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .reg_write_o     (reg_write_o),
    .wb_sel_o        (wb_sel_o),
    .instr_retired_o (instr_retired_o),
    .state_o         (state_o),
    .illegal_o       (illegal_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got[21:0], want[21:0]);
    end
  endtask

  function automatic outs_t observed();
    outs_t o;
    o.mem_req       = mem_req_o;
    o.mem_we        = mem_we_o;
    o.mem_addr_sel  = mem_addr_sel_o;
    o.ir_write      = ir_write_o;
    o.pc_write      = pc_write_o;
    o.pc_src        = pc_src_o;
    o.extend_sel    = extend_sel_o;
    o.alu_src_a     = alu_src_a_o;
    o.alu_src_b     = alu_src_b_o;
    o.alu_op        = alu_op_o;
    o.reg_write     = reg_write_o;
    o.wb_sel        = wb_sel_o;
    o.instr_retired = instr_retired_o;
    o.state         = state_o;
    o.illegal       = illegal_o;
    return o;
  endfunction

  // Fields without a defined value in a given cycle are left out of the compare
  function automatic outs_t care_of(input outs_t e, input bit alu_care, input bit all);
    outs_t c;
    c = '1;
    if (!all) begin
      if (!e.mem_req) begin
        c.mem_we       = 1'b0;
        c.mem_addr_sel = 1'b0;
      end
      if (!e.pc_write) c.pc_src = 2'b00;
      if (e.state != 3'd4) c.wb_sel = 2'b00;
      if (!alu_care) begin
        c.alu_src_a = 2'b00;
        c.alu_src_b = 1'b0;
        c.alu_op    = 2'b00;
      end
      if (e.state == 3'd0 || e.state == 3'd5) c.extend_sel = 2'b00;
    end
    return c;
  endfunction

  // One clock: drive inputs, queue the expectation, compare at the falling edge
  task automatic cyc(input logic rdy, input logic rst, input string tag,
                     input outs_t e, input bit alu_care);
    outs_t g, c, w;
    logic [31:0] gv, wv;
    mem_ready_i = rdy;
    rst_i       = rst;
    exp_q.push_back(e);
    care_q.push_back(care_of(e, alu_care, rst));
    tag_q.push_back(tag);
    @(negedge clk_i);
    g  = observed();
    c  = care_q.pop_front();
    w  = exp_q.pop_front();
    gv = '0;
    wv = '0;
    gv[21:0] = g & c;
    wv[21:0] = w & c;
    check_eq(tag_q.pop_front(), gv, wv);
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_instr(input string name, input logic [6:0] op, input logic taken,
                           input int fw, input int mw, input bit rst_in_mem);
    outs_t      e;
    int         n;
    logic [1:0] ext;
    bit         legal, is_load, is_store, short_exit;
    n = 0;
    opcode_i       = op;
    branch_taken_i = taken;
    legal    = (op == LUI) || (op == AUIPC) || (op == JAL) || (op == JALR) ||
               (op == BRANCH) || (op == LOAD) || (op == STORE) || (op == OPIMM) ||
               (op == OP) || (op == FENCE) || (op == SYSTEM);
    is_load  = (op == LOAD);
    is_store = (op == STORE);
    if (op == LUI || op == AUIPC) ext = 2'b00;
    else if (op == JAL)           ext = 2'b01;
    else if (op == BRANCH)        ext = 2'b10;
    else                          ext = 2'b11;

    for (int i = 0; i <= fw; i++) begin
      e = '0;
      e.mem_req  = 1'b1;
      e.ir_write = (i == fw);
      cyc(i == fw, 1'b0, {name, "/fetch"}, e, 1'b0);
      n++;
    end

    e = '0;
    e.state      = 3'd1;
    e.extend_sel = ext;
    cyc(1'b1, 1'b0, {name, "/decode"}, e, 1'b0);
    n++;

`ifdef ILLEGAL_TRAP_EN
    if (!legal) begin
      for (int i = 0; i < 3; i++) begin
        e = '0;
        e.state   = 3'd5;
        e.illegal = 1'b1;
        cyc(1'b1, 1'b0, {name, "/trap"}, e, 1'b0);
        n++;
      end
      $display("txn %s op=%b trapped after %0d cycles", name, op, n);
      return;
    end
`endif

    e = '0;
    e.state      = 3'd2;
    e.extend_sel = ext;
    e.alu_src_b  = 1'b1;
    case (op)
      LUI:        e.alu_src_a = 2'b10;
      AUIPC, JAL: e.alu_src_a = 2'b01;
      OPIMM:      e.alu_op    = 2'b11;
      OP: begin
        e.alu_src_b = 1'b0;
        e.alu_op    = 2'b10;
      end
      BRANCH: begin
        e.alu_src_b = 1'b0;
        e.alu_op    = 2'b01;
      end
      default: ;
    endcase
    short_exit = (op == BRANCH) || (op == FENCE) || (op == SYSTEM) || !legal;
    if (short_exit) begin
      e.pc_write      = 1'b1;
      e.instr_retired = 1'b1;
      e.pc_src        = (op == BRANCH && taken) ? 2'b01 : 2'b00;
    end
    cyc(1'b1, 1'b0, {name, "/exec"}, e, legal && op != FENCE && op != SYSTEM);
    n++;
    if (short_exit) begin
      $display("txn %s op=%b retired in %0d cycles", name, op, n);
      return;
    end

    if (is_load || is_store) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0;
        e.state        = 3'd3;
        e.extend_sel   = ext;
        e.mem_req      = 1'b1;
        e.mem_addr_sel = 1'b1;
        e.mem_we       = is_store;
        if (i == mw && is_store && !rst_in_mem) begin
          e.pc_write      = 1'b1;
          e.instr_retired = 1'b1;
        end
        if (rst_in_mem) begin
          cyc(1'b0, 1'b0, {name, "/mem_wait"}, e, 1'b0);
          cyc(1'b0, 1'b1, {name, "/mem_reset"}, '0, 1'b0);
          $display("txn %s op=%b aborted by reset after %0d cycles", name, op, n + 2);
          return;
        end
        cyc(i == mw, 1'b0, {name, "/mem"}, e, 1'b0);
        n++;
      end
      if (is_store) begin
        $display("txn %s op=%b retired in %0d cycles", name, op, n);
        return;
      end
    end

    e = '0;
    e.state         = 3'd4;
    e.extend_sel    = ext;
    e.reg_write     = 1'b1;
    e.pc_write      = 1'b1;
    e.instr_retired = 1'b1;
    if (is_load)                      e.wb_sel = 2'b01;
    else if (op == JAL || op == JALR) e.wb_sel = 2'b10;
    if (op == JAL)       e.pc_src = 2'b01;
    else if (op == JALR) e.pc_src = 2'b10;
    cyc(1'b1, 1'b0, {name, "/wb"}, e, 1'b0);
    n++;
    $display("txn %s op=%b retired in %0d cycles", name, op, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit expired");
  end

  initial begin
    @(posedge clk_i);
    #1;
    cyc(1'b1, 1'b1, "reset0", '0, 1'b0);
    cyc(1'b0, 1'b1, "reset1", '0, 1'b0);

    run_instr("addi",      OPIMM,  1'b0, 0, 0, 1'b0);
    run_instr("lw_wait2",  LOAD,   1'b0, 0, 2, 1'b0);
    run_instr("beq_taken", BRANCH, 1'b1, 0, 0, 1'b0);
    run_instr("beq_not",   BRANCH, 1'b0, 0, 0, 1'b0);
    run_instr("jal",       JAL,    1'b0, 0, 0, 1'b0);
    run_instr("jalr",      JALR,   1'b1, 0, 0, 1'b0);
    run_instr("lui",       LUI,    1'b0, 0, 0, 1'b0);
    run_instr("auipc",     AUIPC,  1'b0, 1, 0, 1'b0);
    run_instr("add",       OP,     1'b0, 0, 0, 1'b0);
    run_instr("fence",     FENCE,  1'b0, 0, 0, 1'b0);
    run_instr("ecall",     SYSTEM, 1'b1, 2, 0, 1'b0);
    run_instr("sw_wait1",  STORE,  1'b0, 1, 1, 1'b0);
    run_instr("lw_fwait",  LOAD,   1'b0, 2, 0, 1'b0);
    run_instr("sw_abort",  STORE,  1'b0, 0, 0, 1'b1);
    run_instr("lw_after",  LOAD,   1'b0, 0, 1, 1'b0);
    run_instr("illegal",   7'b1111111, 1'b0, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    cyc(1'b1, 1'b1, "trap_reset", '0, 1'b0);
`endif
    run_instr("addi_end",  OPIMM,  1'b0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
